// File: rtl/bin_to_bcd_seq.sv
`timescale 1ns/1ps
// bin_to_bcd_seq
//   Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
//   Produces NDIGITS packed BCD nibbles for the per-digit 7-segment decoders.
//   Codes 0..9 are digits; on overflow every nibble is 4'hF, which the decoder
//   shows as its non-digit pattern.
//
//   Build option: define BIN2BCD_SAT_EN to saturate overflowed results to all
//   nines instead of the all-4'hF marker. Non-overflow results are the same in
//   both builds.
//
// Parameters
//   IN_WIDTH  width of BinIn (1..20)
//   NDIGITS   number of BCD digits (1..6)
//
// Ports
//   Clk       clock, all state on the rising edge
//   Reset     synchronous active-high reset
//   Start     conversion request, only looked at while idle
//   BinIn     binary value, captured when Start is accepted
//   Busy      high from the cycle after acceptance through the Done cycle
//   Done      one-cycle pulse; Bcd/Overflow carry the new result in that cycle
//   Overflow  last result exceeded 10**NDIGITS-1; held until the next Done
//   Bcd       packed digits, [3:0] = units; held between conversions
module bin_to_bcd_seq #(
    parameter int unsigned IN_WIDTH = 9,
    parameter int unsigned NDIGITS  = 3
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic [IN_WIDTH-1:0]   BinIn,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Overflow,
    output logic [4*NDIGITS-1:0]  Bcd
);

    localparam int unsigned BW = 4 * NDIGITS;
    localparam int unsigned CW = $clog2(IN_WIDTH + 1);
    localparam logic [31:0] MAX_VAL = 32'(10 ** NDIGITS - 1);

`ifdef BIN2BCD_SAT_EN
    localparam logic [BW-1:0] OVF_CODE = {NDIGITS{4'h9}};
`else
    localparam logic [BW-1:0] OVF_CODE = {NDIGITS{4'hF}};
`endif

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t              state_q;
    logic [IN_WIDTH-1:0] shift_q;
    logic [BW-1:0]       digits_q;
    logic [CW-1:0]       cnt_q;
    logic                ovf_pend_q;

    logic [BW-1:0]       digits_adj;
    logic [BW-1:0]       digits_next;
    logic [IN_WIDTH-1:0] shift_next;
    logic                ovf_in;

    // One double-dabble step: add 3 to every digit >= 5, then shift the whole
    // {digits, shift register} left by one. The carry out of the top digit falls
    // off the end; it can only be set when the input overflowed anyway.
    always_comb begin
        digits_adj = '0;
        for (int i = 0; i < int'(NDIGITS); i++) begin
            if (digits_q[4*i +: 4] >= 4'd5) begin
                digits_adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
            end else begin
                digits_adj[4*i +: 4] = digits_q[4*i +: 4];
            end
        end
        {digits_next, shift_next} = {digits_adj, shift_q} << 1;
    end

    assign ovf_in = (32'(BinIn) > MAX_VAL);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            digits_q   <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
            Overflow   <= 1'b0;
            Bcd        <= '0;
        end else begin
            Done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (Start) begin
                        shift_q    <= BinIn;
                        digits_q   <= '0;
                        cnt_q      <= CW'(IN_WIDTH);
                        ovf_pend_q <= ovf_in;
                        Busy       <= 1'b1;
                        state_q    <= StShift;
                    end
                end
                StShift: begin
                    shift_q  <= shift_next;
                    digits_q <= digits_next;
                    cnt_q    <= cnt_q - CW'(1);
                    // The result is published on the edge into StDone so that
                    // Bcd and Done are valid in the same cycle.
                    if (cnt_q == CW'(1)) begin
                        state_q  <= StDone;
                        Done     <= 1'b1;
                        Overflow <= ovf_pend_q;
                        Bcd      <= ovf_pend_q ? OVF_CODE : digits_next;
                    end
                end
                StDone: begin
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    Busy    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
`timescale 1ns/1ps
// Testbench for bin_to_bcd_seq: two instances (9-bit/3-digit and 7-bit/2-digit).
// Expected results are queued when a conversion is started; a monitor per
// instance pops and compares whenever Done is seen.
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_a, start_b;
    logic [8:0]  bin_a;
    logic [6:0]  bin_b;
    logic        busy_a, done_a, ovf_a;
    logic        busy_b, done_b, ovf_b;
    logic [11:0] bcd_a;
    logic [7:0]  bcd_b;

`ifdef BIN2BCD_SAT_EN
    localparam logic [7:0] OVF_B = 8'h99;
`else
    localparam logic [7:0] OVF_B = 8'hFF;
`endif

    bin_to_bcd_seq #(.IN_WIDTH(9), .NDIGITS(3)) dut_a (
        .Clk(clk), .Reset(reset), .Start(start_a), .BinIn(bin_a),
        .Busy(busy_a), .Done(done_a), .Overflow(ovf_a), .Bcd(bcd_a)
    );

    bin_to_bcd_seq #(.IN_WIDTH(7), .NDIGITS(2)) dut_b (
        .Clk(clk), .Reset(reset), .Start(start_b), .BinIn(bin_b),
        .Busy(busy_b), .Done(done_b), .Overflow(ovf_b), .Bcd(bcd_b)
    );

    int n_pass  = 0;
    int n_total = 0;
    int dones_a = 0;
    int dones_b = 0;
    logic [12:0] q_a[$];
    logic [8:0]  q_b[$];
    logic [12:0] ea;
    logic [8:0]  eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done_a(input string name);
        int k = 0;
        while (done_a !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk(name, done_a, 1);
    endtask

    task automatic wait_done_b(input string name);
        int k = 0;
        while (done_b !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        chk(name, done_b, 1);
    endtask

    task automatic convert_b(input logic [6:0] v, input logic ovf, input logic [7:0] bcd);
        q_b.push_back({ovf, bcd});
        start_b = 1'b1;
        bin_b   = v;
        tick();
        start_b = 1'b0;
        wait_done_b("b_done_seen");
        tick();
    endtask

    // Monitors
    always @(posedge clk) begin
        #1;
        if (done_a === 1'b1) begin
            dones_a++;
            chk("a_done_expected", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                chk("a_bcd", bcd_a, ea[11:0]);
                chk("a_ovf", ovf_a, ea[12]);
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (done_b === 1'b1) begin
            dones_b++;
            chk("b_done_expected", q_b.size() != 0, 1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                chk("b_bcd", bcd_b, eb[7:0]);
                chk("b_ovf", ovf_b, eb[8]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int busy_n;
        int d0;
        logic stable;

        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; bin_a = '0; bin_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_busy_a", busy_a, 0);
        chk("rst_done_a", done_a, 0);
        chk("rst_ovf_a", ovf_a, 0);
        chk("rst_bcd_a", bcd_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_bcd_b", bcd_b, 0);

        // 1: 345, latency and Busy length
        q_a.push_back({1'b0, 12'h345});
        start_a = 1'b1; bin_a = 9'd345;
        tick();
        start_a = 1'b0; bin_a = 9'd511;
        chk("t1_accept_busy", busy_a, 1);
        lat = 0; busy_n = 1; stable = 1'b1;
        while (done_a !== 1'b1 && lat < 40) begin
            tick();
            lat++;
            if (busy_a === 1'b1) busy_n++;
            if (done_a !== 1'b1 && bcd_a !== 12'h000) stable = 1'b0;
        end
        chk("t1_latency", lat, 9);
        chk("t1_busy_cycles", busy_n, 10);
        chk("t1_no_partial_bcd", stable, 1);
        tick();
        chk("t1_idle_after", busy_a, 0);

        // 2: 0 then 511 with Start held
        q_a.push_back({1'b0, 12'h000});
        q_a.push_back({1'b0, 12'h511});
        start_a = 1'b1; bin_a = 9'd0;
        tick();
        chk("t2_accept1", busy_a, 1);
        bin_a = 9'd511;
        wait_done_a("t2_done1");
        tick();
        chk("t2_idle_between", busy_a, 0);
        tick();
        chk("t2_accept2", busy_a, 1);
        start_a = 1'b0;
        wait_done_a("t2_done2");
        tick();

        // 3: two-digit instance boundaries
        convert_b(7'd99, 1'b0, 8'h99);
        convert_b(7'd100, 1'b1, OVF_B);
        repeat (3) tick();
        chk("t3_ovf_held", ovf_b, 1);
        chk("t3_bcd_held", bcd_b, OVF_B);
        convert_b(7'd127, 1'b1, OVF_B);
        convert_b(7'd0, 1'b0, 8'h00);
        chk("t3_ovf_cleared", ovf_b, 0);

        // 4: Start during SHIFT is ignored
        q_a.push_back({1'b0, 12'h200});
        start_a = 1'b1; bin_a = 9'd200;
        tick();
        start_a = 1'b0;
        tick(); tick();
        start_a = 1'b1; bin_a = 9'd7;
        tick();
        start_a = 1'b0;
        d0 = dones_a;
        wait_done_a("t4_done");
        repeat (15) tick();
        chk("t4_single_done", dones_a - d0, 1);
        chk("t4_still_200", bcd_a, 12'h200);

        // 5: reset mid-conversion
        start_a = 1'b1; bin_a = 9'd345;
        tick();
        start_a = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_busy", busy_a, 0);
        chk("t5_done", done_a, 0);
        chk("t5_bcd", bcd_a, 0);
        chk("t5_ovf", ovf_a, 0);
        d0 = dones_a;
        repeat (20) tick();
        chk("t5_no_done", dones_a - d0, 0);

        // 6: result held while BinIn wanders
        q_a.push_back({1'b0, 12'h123});
        start_a = 1'b1; bin_a = 9'd123;
        tick();
        start_a = 1'b0;
        wait_done_a("t6_done");
        for (int i = 0; i < 20; i++) begin
            bin_a = 9'($urandom);
            tick();
            chk("t6_bcd_hold", bcd_a, 12'h123);
            chk("t6_ovf_hold", ovf_a, 0);
            chk("t6_busy_low", busy_a, 0);
        end

        repeat (3) tick();
        chk("queues_drained", q_a.size() + q_b.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
